// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds the fetch FSM encoding and the PC stepping constants.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    KILL,
    HOLD
  } if_state_e;

  localparam int unsigned INSTR_BYTES_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

  // Branch targets are word aligned; low address bits are dropped.
  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// Single-entry buffer parking a fetched word and its PC while
// decode is stalled; clear wins over load.
module if_hold_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] word_i,
  input  logic [31:0] pc_i,
  output logic [31:0] word_o,
  output logic [31:0] pc_o
);

  logic [31:0] word_q, word_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    word_d = word_q;
    pc_d   = pc_q;
    if (clear_i) begin
      word_d = '0;
      pc_d   = '0;
    end else if (load_i) begin
      word_d = word_i;
      pc_d   = pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      pc_q   <= '0;
    end else begin
      word_q <= word_d;
      pc_q   <= pc_d;
    end
  end

  assign word_o = word_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single outstanding request, decode
// stall via hold buffer, branch redirect with in-flight kill.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_Addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        IF_valid
);

  localparam logic [31:0] STEP = 32'(INSTR_BYTES);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pco_q, pco_d;
  logic        valid_q, valid_d;

  logic        hb_load;
  logic        hb_clear;
  logic [31:0] hb_word;
  logic [31:0] hb_pc;
  logic [31:0] pc_inc;
  logic [31:0] br_tgt;

  assign pc_inc = pc_q + STEP;
  assign br_tgt = align_pc(Br_Addr);

  if_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hb_load),
    .clear_i (hb_clear),
    .word_i  (imem_rdata),
    .pc_i    (pc_inc),
    .word_o  (hb_word),
    .pc_o    (hb_pc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    instr_d  = instr_q;
    pco_d    = pco_q;
    valid_d  = valid_q;
    hb_load  = 1'b0;
    hb_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (Br_taken) begin
          pc_d    = br_tgt;
          valid_d = 1'b0;
        end
      end
      FETCH: begin
        if (Br_taken) begin
          valid_d  = 1'b0;
          hb_clear = 1'b1;
          if (imem_ack) begin
            pc_d = br_tgt;
          end else begin
            tgt_d   = br_tgt;
            state_d = KILL;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (freeze) begin
            hb_load = 1'b1;
            state_d = HOLD;
          end else begin
            instr_d = imem_rdata;
            pco_d   = pc_inc;
            valid_d = 1'b1;
          end
        end else if (!freeze) begin
          valid_d = 1'b0;
        end
      end
      KILL: begin
        // The request in flight belongs to the squashed path.
        valid_d = 1'b0;
        if (Br_taken) tgt_d = br_tgt;
        if (imem_ack) begin
          pc_d    = Br_taken ? br_tgt : tgt_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (Br_taken) begin
          pc_d     = br_tgt;
          valid_d  = 1'b0;
          hb_clear = 1'b1;
          state_d  = FETCH;
        end else if (!freeze) begin
          instr_d  = hb_word;
          pco_d    = hb_pc;
          valid_d  = 1'b1;
          hb_clear = 1'b1;
          state_d  = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      instr_q <= '0;
      pco_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == KILL);
  assign imem_addr   = pc_q;
  assign Instruction = instr_q;
  assign PC          = pco_q;
  assign IF_valid    = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against an in-order program-stream
// model with a variable-latency instruction memory.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        Br_taken;
  logic [31:0] Br_Addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        IF_valid;

  if_stage #(
    .RESET_PC    (RST_PC),
    .INSTR_BYTES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .Br_taken    (Br_taken),
    .Br_Addr     (Br_Addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .PC          (PC),
    .IF_valid    (IF_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[17:2], a[17:2]} ^ 32'h1357_9BDF;
  endfunction

  // program-stream model and memory state
  logic [31:0] exp_pc, kill_tgt, prev_addr, prev_tgt, force_tgt;
  logic        kill, prev_req, prev_ack, prev_br, prev_frz;
  logic        prev_kill, prev_idle, force_br;
  int          wait_cnt, lat, lat_min, lat_max, frz_pct, br_pct;
  int          consumed, idle_run, idle_max, frz_left;
  logic [31:0] frz_addr;
  bit          frz_done, wrap_seen;

  task automatic step();
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    logic        exp_req;
    @(negedge clk);
    if (prev_idle) begin
      chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, RST_PC);
    end else if (prev_req && !prev_ack) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, prev_addr);
    end else begin
      if (prev_br)        exp_addr = prev_tgt;
      else if (prev_req)  exp_addr = prev_kill ? kill_tgt
                                               : prev_addr + 32'd4;
      else                exp_addr = prev_addr;
      exp_req = prev_br || prev_kill || !prev_frz;
      chk("next_req", imem_req, exp_req);
      chk("next_addr", imem_addr, exp_addr);
    end
    if (prev_br) chk("flush_bubble", IF_valid, 0);
    if (kill)    chk("kill_bubble", IF_valid, 0);

    if (!frz_done && imem_req && imem_addr == frz_addr) begin
      frz_left = 4;
      frz_done = 1;
    end
    if (frz_left > 0) begin
      freeze = 1'b1;
      frz_left--;
    end else begin
      freeze = ($urandom_range(99) < frz_pct);
    end
    if (force_br) begin
      Br_taken = 1'b1;
      Br_Addr  = force_tgt;
      force_br = 1'b0;
    end else begin
      Br_taken = ($urandom_range(99) < br_pct);
      Br_Addr  = $urandom_range(32'h3FF);
    end
    if (imem_req) begin
      if (wait_cnt == 0) lat = $urandom_range(lat_max, lat_min);
      imem_ack = (wait_cnt >= lat);
    end else begin
      imem_ack = 1'b0;
    end
    imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hBAD0_BAD0;

    tgt = {Br_Addr[31:2], 2'b00};
    if (IF_valid && !freeze && !Br_taken) begin
      chk("instr", Instruction, mem_word(exp_pc));
      chk("pc", PC, exp_pc + 32'd4);
      if (exp_pc == 32'hFFFF_FFFC) wrap_seen = 1;
      exp_pc += 32'd4;
      consumed++;
      idle_run = 0;
    end else begin
      idle_run++;
    end
    if (idle_run > idle_max) idle_max = idle_run;
    if (Br_taken) exp_pc = tgt;

    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
    prev_br   = Br_taken;
    prev_frz  = freeze;
    prev_tgt  = tgt;
    prev_kill = kill;
    prev_idle = 1'b0;
    if (imem_req) begin
      if (Br_taken && !imem_ack) begin
        kill     = 1'b1;
        kill_tgt = tgt;
      end else if (imem_ack) begin
        kill = 1'b0;
      end
    end
    @(posedge clk);
    if (prev_req && prev_ack) wait_cnt = 0;
    else if (prev_req)        wait_cnt++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    freeze     = 1'b0;
    Br_taken   = 1'b0;
    Br_Addr    = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_instr", Instruction, 0);
    chk("rst_pc", PC, 0);
    chk("rst_valid", IF_valid, 0);
    @(negedge clk);
    rst       = 1'b0;
    exp_pc    = RST_PC;
    wait_cnt  = 0;
    kill      = 1'b0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_br   = 1'b0;
    prev_frz  = 1'b0;
    prev_kill = 1'b0;
    prev_idle = 1'b1;
    prev_addr = RST_PC;
    idle_run  = 0;
  endtask

  initial begin
    kill_tgt  = '0;
    prev_tgt  = '0;
    force_br  = 1'b0;
    force_tgt = '0;
    lat       = 0;
    consumed  = 0;
    idle_max  = 0;
    frz_left  = 0;
    frz_addr  = 32'h10;
    frz_done  = 0;
    wrap_seen = 0;
    lat_min   = 0;
    lat_max   = 0;
    frz_pct   = 0;
    br_pct    = 0;
    do_reset();

    // zero-wait streaming, with a 4-cycle stall landing at 0x10
    step();
    #1;
    chk("c2_valid", IF_valid, 1);
    chk("c2_pc", PC, 32'd4);
    repeat (20) step();
    chk("frz_hit", frz_done, 1);

    // slow memory, branch during an outstanding fetch
    lat_min = 3;
    lat_max = 3;
    repeat (5) step();
    force_br  = 1'b1;
    force_tgt = 32'h103;
    repeat (20) step();

    // random mix of latency, stalls and redirects
    lat_min = 0;
    lat_max = 3;
    frz_pct = 25;
    br_pct  = 8;
    repeat (1500) step();

    // address wrap
    br_pct    = 0;
    frz_pct   = 10;
    force_br  = 1'b1;
    force_tgt = 32'hFFFF_FFF9;
    repeat (30) step();
    chk("wrap_seen", wrap_seen, 1);

    // asynchronous reset in the middle of a long wait
    lat_min = 6;
    lat_max = 6;
    frz_pct = 0;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_instr", Instruction, 0);
    chk("arst_pc", PC, 0);
    chk("arst_valid", IF_valid, 0);
    do_reset();
    lat_min = 0;
    lat_max = 2;
    frz_pct = 20;
    br_pct  = 5;
    repeat (300) step();

    chk("progress", idle_max < 100, 1);
    chk("consumed", consumed > 500, 1);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
